ext_strip_tx: RTL and testbench

//   Transmit side of the extension-compressed word link. Accepts full DW-bit words
//   and emits the minimum number of BW-bit chunks needed to rebuild the word.
//   The receiver rebuilds the word by zero-extending or sign-extending the chunks.

---
 rtl/ext_pkg.sv | 15 +
 rtl/ext_len_calc.sv | 37 +++
 rtl/ext_strip_tx.sv | 92 +++++++++
 tb/tb_ext_strip_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the extension-compressed word link (tx and rx).
// Sign mode is selected by the EXT_STRIP_SIGN_EN macro in ext_len_calc.
package ext_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DW_DEF = 32;
    localparam int BW_DEF = 8;
    localparam int NB_DEF = DW_DEF / BW_DEF;
    localparam int CW_DEF = $clog2(NB_DEF + 1);

endpackage

// File: rtl/ext_len_calc.sv
// Retained chunk count of a word; high-order redundant chunks are dropped.
// Macro EXT_STRIP_SIGN_EN selects sign-extension instead of zero-extension.
module ext_len_calc
    import ext_pkg::*;
#(
    parameter  int DW = DW_DEF,
    parameter  int BW = BW_DEF,
    localparam int NB = DW / BW,
    localparam int CW = $clog2(NB + 1)
) (
    input  logic [DW-1:0] data,
    output logic [CW-1:0] cnt
);

    logic stop;
    logic drop;

    always_comb begin
        cnt  = CW'(NB);
        stop = 1'b0;
        drop = 1'b0;
        // Walk down from the top chunk; chunk 0 is never dropped.
        for (int i = NB - 1; i >= 1; i--) begin
`ifdef EXT_STRIP_SIGN_EN
            drop = (data[i*BW +: BW] == {BW{data[i*BW-1]}});
`else
            drop = (data[i*BW +: BW] == '0);
`endif
            if (!stop && drop) begin
                cnt = CW'(i);
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_strip_tx.sv
// Transmit side of the extension-compressed link: word in, minimal chunks out.
// Macro EXT_STRIP_SIGN_EN (in ext_len_calc) enables sign-mode stripping.
module ext_strip_tx
    import ext_pkg::*;
#(
    parameter  int DW = DW_DEF,
    parameter  int BW = BW_DEF,
    localparam int CW = $clog2(DW / BW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_last,
    output logic [CW-1:0] out_cnt
);

    state_t        state;
    logic [DW-1:0] word;
    logic [CW-1:0] index;
    logic [CW-1:0] nidx;
    logic [CW-1:0] n_calc;
    logic          accept;

    ext_len_calc #(
        .DW(DW),
        .BW(BW)
    ) u_len (
        .data(in_data),
        .cnt (n_calc)
    );

    // Accepting on the last-chunk handshake gives back-to-back words.
    assign in_ready = (state == IDLE) | (out_valid & out_ready & out_last);
    assign accept   = in_valid & in_ready;
    assign nidx     = index + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            index     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SEND;
                        word      <= in_data;
                        index     <= '0;
                        out_valid <= 1'b1;
                        out_data  <= in_data[BW-1:0];
                        out_last  <= (n_calc == CW'(1));
                        out_cnt   <= n_calc;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (!out_last) begin
                            index    <= nidx;
                            out_data <= word[nidx*BW +: BW];
                            out_last <= (nidx == out_cnt - CW'(1));
                        end else if (accept) begin
                            word      <= in_data;
                            index     <= '0;
                            out_valid <= 1'b1;
                            out_data  <= in_data[BW-1:0];
                            out_last  <= (n_calc == CW'(1));
                            out_cnt   <= n_calc;
                        end else begin
                            state     <= IDLE;
                            index     <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            out_cnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_strip_tx.sv
// Randomized scoreboard bench for ext_strip_tx against an arithmetic model.
// Builds for zero mode by default, sign mode with EXT_STRIP_SIGN_EN.
module tb_ext_strip_tx;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic [2:0] cnt;
    } chunk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_cnt;

    int     checks = 0;
    int     failures = 0;
    chunk_t q[$];
    bit     rnd_ready = 0;
    bit     prev_stall = 0;
    chunk_t held;
    int     cyc = 0;
    int     hs_cnt = 0;
    int     hs_first = 0;
    int     hs_last = 0;

    ext_strip_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_cnt  (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Smallest n whose low n bytes, extended, reproduce the word.
    function automatic int model_n(input logic [31:0] w);
        longint sw;
        longint lim;
        sw = longint'(signed'(w));
        for (int n = 1; n < 4; n++) begin
`ifdef EXT_STRIP_SIGN_EN
            lim = 64'sd1 <<< (8 * n - 1);
            if (sw >= -lim && sw < lim) return n;
`else
            lim = 64'sd1 <<< (8 * n);
            if (longint'(w) < lim) return n;
`endif
        end
        return 4;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] m;
        m = (32'h1 << $urandom_range(0, 31)) - 32'h1;
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return $urandom & m;
            2: return ~($urandom & m);
            3: return 32'h80 << (8 * $urandom_range(0, 3));
            default: return 32'h7F << (8 * $urandom_range(0, 3));
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        chunk_t e;
        int     n;
        cyc++;
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held.d);
                chk("stall_last", out_last, held.last);
                chk("stall_cnt", out_cnt, held.cnt);
            end
            prev_stall = out_valid && !out_ready;
            held = '{out_data, out_last, out_cnt};
            if (out_valid && out_ready) begin
                if (hs_cnt == 0) hs_first = cyc;
                hs_last = cyc;
                hs_cnt++;
                if (q.size() == 0) begin
                    chk("spurious_chunk", out_data, 0);
                    chk("spurious_valid", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("data", out_data, e.d);
                    chk("last", out_last, e.last);
                    chk("cnt", out_cnt, e.cnt);
                end
            end
            if (in_valid && in_ready) begin
                n = model_n(in_data);
                for (int i = 0; i < n; i++)
                    q.push_back('{in_data[i*8 +: 8], i == n - 1, 3'(n)});
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [31:0] w, input int exp_n);
        send_word(w);
        @(negedge clk);
        chk("first_latency", out_valid, 1);
        chk("cnt_tbl", out_cnt, exp_n);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);

`ifdef EXT_STRIP_SIGN_EN
        send_chk(32'h0000_0000, 1); drain();
        send_chk(32'h0000_1234, 2); drain();
        send_chk(32'hFFFF_FF80, 1); drain();
        send_chk(32'hFFFF_FF7F, 2); drain();
        send_chk(32'h0000_0080, 2); drain();
`else
        send_chk(32'h0000_0000, 1); drain();
        send_chk(32'h0000_1234, 2); drain();
        send_chk(32'hFFFF_FF80, 4); drain();
        send_chk(32'hFFFF_FF7F, 4); drain();
        send_chk(32'h0000_0080, 1); drain();
`endif

        hs_cnt = 0;
        send_word(32'h12);
        send_word(32'h3456);
        drain();
        chk("b2b_chunks", hs_cnt, 3);
        chk("b2b_no_bubble", hs_last - hs_first, 2);

        send_word(32'h1234_5678);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        send_word(32'h1234_5678);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        q.delete();
        prev_stall = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        send_chk(32'h1234_5678, 4);
        drain();

        rnd_ready = 1;
        repeat (300) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(rnd_word());
        end
        drain();
        rnd_ready = 0;
        #1 out_ready = 1'b1;
        chk("final_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
